// File: rtl/acc_c_arbiter.sv
// acc_c_arbiter: round-robin arbiter sharing one C-bus request/response
// channel pair among NumReq upstream adapters. Granted requests are tagged
// with the requester index in the id MSBs, and responses are routed back
// using that tag. Each requester has a limit on outstanding transactions.
module acc_c_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 133,
  parameter int unsigned RspWidth       = 33,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned SelWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  // upstream request channels
  input  logic [NumReq-1:0]                   slv_q_valid_i,
  output logic [NumReq-1:0]                   slv_q_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]     slv_q_i,
  input  logic [NumReq-1:0][IdWidth-1:0]      slv_q_id_i,
  // upstream response channels (payload and id broadcast)
  output logic [NumReq-1:0]                   slv_p_valid_o,
  input  logic [NumReq-1:0]                   slv_p_ready_i,
  output logic [RspWidth-1:0]                 slv_p_o,
  output logic [IdWidth-1:0]                  slv_p_id_o,
  // shared request channel
  output logic                                mst_q_valid_o,
  input  logic                                mst_q_ready_i,
  output logic [ReqWidth-1:0]                 mst_q_o,
  output logic [SelWidth+IdWidth-1:0]         mst_q_id_o,
  // shared response channel
  input  logic                                mst_p_valid_i,
  output logic                                mst_p_ready_o,
  input  logic [RspWidth-1:0]                 mst_p_i,
  input  logic [SelWidth+IdWidth-1:0]         mst_p_id_i,
  // status
  output logic [NumReq-1:0]                   busy_o,
  output logic                                err_o
);

  logic [SelWidth-1:0]               rr_q;
  logic                              lock_q;
  logic [SelWidth-1:0]               lock_idx_q;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_q;

  logic [NumReq-1:0]                 eligible;
  logic [NumReq-1:0]                 cnt_zero;
  logic                              grant_valid;
  logic [SelWidth-1:0]               grant_idx;
  logic [SelWidth-1:0]               cand;
  logic                              q_hs;
  logic [NumReq-1:0]                 q_inc;
  logic [NumReq-1:0]                 p_hs;
  logic [SelWidth-1:0]               p_sel;
  logic                              p_sel_ok;

  // requester eligibility: valid and below its outstanding limit
  always_comb begin
    eligible = '0;
    cnt_zero = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = slv_q_valid_i[i] && (cnt_q[i] != CntWidth'(MaxOutstanding));
      cnt_zero[i] = (cnt_q[i] == '0);
    end
  end

  // grant select: locked index while stalled, else first eligible from rr_q
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        cand = SelWidth'((32'(rr_q) + 32'(k)) % NumReq);
        if (!grant_valid && eligible[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign mst_q_valid_o = grant_valid;
  assign mst_q_o       = slv_q_i[grant_idx];
  assign mst_q_id_o    = {grant_idx, slv_q_id_i[grant_idx]};
  assign q_hs          = grant_valid && mst_q_ready_i;

  // per-requester ready and handshake strobes for the granted index only
  always_comb begin
    slv_q_ready_o = '0;
    q_inc         = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_valid && (grant_idx == SelWidth'(i))) begin
        slv_q_ready_o[i] = mst_q_ready_i;
        q_inc[i]         = mst_q_ready_i;
      end
    end
  end

  assign p_sel = mst_p_id_i[SelWidth+IdWidth-1:IdWidth];

  // tags beyond NumReq can only occur when NumReq is not a power of two
  generate
    if ((1 << SelWidth) > NumReq) begin : g_sel_chk
      assign p_sel_ok = (p_sel < SelWidth'(NumReq));
    end else begin : g_sel_full
      assign p_sel_ok = 1'b1;
    end
  endgenerate

  // response routing; unknown tags are swallowed so the bus never stalls
  always_comb begin
    slv_p_valid_o = '0;
    p_hs          = '0;
    mst_p_ready_o = 1'b1;
    if (p_sel_ok) begin
      mst_p_ready_o = slv_p_ready_i[p_sel];
    end
    for (int i = 0; i < NumReq; i++) begin
      if (p_sel_ok && (p_sel == SelWidth'(i))) begin
        slv_p_valid_o[i] = mst_p_valid_i;
        p_hs[i]          = mst_p_valid_i && slv_p_ready_i[i];
      end
    end
  end

  assign slv_p_o    = mst_p_i;
  assign slv_p_id_o = mst_p_id_i[IdWidth-1:0];

  // round-robin pointer, stall lock and bad-tag error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= mst_p_valid_i && !p_sel_ok;
      if (q_hs) begin
        lock_q <= 1'b0;
        rr_q   <= (grant_idx == SelWidth'(NumReq - 1)) ? '0 : grant_idx + SelWidth'(1);
      end else if (grant_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
    end
  end

  // outstanding counters; simultaneous issue and retire cancel out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (q_inc[i] && !p_hs[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (p_hs[i] && !q_inc[i] && !cnt_zero[i]) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
    end
  end

  assign busy_o = ~cnt_zero;

  // a response must never retire a transaction that was never issued
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (p_hs & ~q_inc & cnt_zero) == '0);

endmodule

// File: doc/acc_c_arbiter.md
# acc_c_arbiter

Round-robin arbiter that shares one accelerator-interconnect request/response channel pair (C-bus) among `NumReq` upstream adapters. It tags every granted request with the requester index in the id MSBs and routes each response back to its requester using that tag. It enforces a per-requester limit on outstanding transactions. It sits between the per-core offload adapters' output FIFOs and the shared accelerator interconnect.

## Interface
- `NumReq`, 4: number of upstream requesters, ≥2.
- `ReqWidth`, 133: opaque request payload width (addr, operands, op).
- `RspWidth`, 33: opaque response payload width.
- `IdWidth`, 5: upstream id width.
- `MaxOutstanding`, 4: outstanding-transaction limit per requester, ≥1.
- `SelWidth`, derived as `cf_math_pkg::idx_width(NumReq)`; DO NOT OVERRIDE.
- `CntWidth`, derived as `$clog2(MaxOutstanding+1)`; DO NOT OVERRIDE.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `slv_q_valid_i`  in  NumReq  per-requester request valid.
- `slv_q_ready_o`  out  NumReq  per-requester request ready.
- `slv_q_i`  in  NumReq×ReqWidth  request payloads.
- `slv_q_id_i`  in  NumReq×IdWidth  request ids.
- `slv_p_valid_o`  out  NumReq  per-requester response valid.
- `slv_p_ready_i`  in  NumReq  per-requester response ready.
- `slv_p_o`  out  RspWidth  response payload, broadcast to all requesters.
- `slv_p_id_o`  out  IdWidth  response id with the tag stripped, broadcast.
- `mst_q_valid_o`  out  1  shared request valid.
- `mst_q_ready_i`  in  1  shared request ready.
- `mst_q_o`  out  ReqWidth  granted request payload.
- `mst_q_id_o`  out  SelWidth+IdWidth  id as {grant index, upstream id}.
- `mst_p_valid_i`  in  1  shared response valid.
- `mst_p_ready_o`  out  1  shared response ready.
- `mst_p_i`  in  RspWidth  response payload.
- `mst_p_id_i`  in  SelWidth+IdWidth  tagged response id.
- `busy_o`  out  NumReq  per-requester flag: outstanding count is non-zero.
- `err_o`  out  1  one-cycle pulse when a response tag is ≥ NumReq.

## Operation
- State:
  - round-robin pointer `rr_q` (SelWidth).
  - lock flag `lock_q` and locked index `lock_idx_q`.
  - per-requester counters `cnt_q[i]` (CntWidth).
  - registered `err_o`.
- Eligibility: requester i is eligible when `slv_q_valid_i[i] && cnt_q[i] != MaxOutstanding`.
- Grant when unlocked:
  - Grant the first eligible index at or after `rr_q`, searching with modular wrap across NumReq.
  - If no requester is eligible, `mst_q_valid_o=0`.
- Grant when locked: the grant is `lock_idx_q`. Eligibility is not re-evaluated.
- Request path (combinational, zero latency):
  - `mst_q_valid_o=1` iff a grant exists.
  - `mst_q_o` and the low bits of `mst_q_id_o` carry the granted payload and id.
  - The upper SelWidth bits of `mst_q_id_o` carry the grant index.
  - `slv_q_ready_o[g]=mst_q_ready_i` for the granted index g; all other bits are 0.
- Lock:
  - Set when `mst_q_valid_o && !mst_q_ready_i`; capture g into `lock_idx_q`.
  - Cleared on handshake.
  - Upstream adapters hold valid and payload stable, so the granted payload does not change while locked.
- Pointer: on a q handshake, `rr_q <= (g==NumReq-1) ? 0 : g+1`. Otherwise it holds.
- Response routing:
  - `sel = mst_p_id_i[MSBs]`.
  - If `sel<NumReq`: `slv_p_valid_o[sel]=mst_p_valid_i` and `mst_p_ready_o=slv_p_ready_i[sel]`.
  - If `sel≥NumReq` (only possible when NumReq is not a power of 2):
    - `mst_p_ready_o=1` and all `slv_p_valid_o` bits are 0, so the response is dropped.
    - `err_o` is registered high for one cycle.
  - `slv_p_o=mst_p_i` and `slv_p_id_o=mst_p_id_i[IdWidth-1:0]`.
- Counter update for `cnt_q[i]`:
  - +1 on a q handshake for i.
  - −1 on a p handshake for i.
  - Unchanged if both happen in the same cycle.
  - Never exceeds MaxOutstanding, because a requester at the limit is ineligible.
  - Never underflows: a p handshake with count 0 is a protocol violation, flagged by assertion, and the counter holds at 0.
- `busy_o[i] = cnt_q[i]!=0`.

## Timing
- Reset (async assert, sync release):
  - `rr_q=0`, `lock_q=0`, all `cnt_q=0`.
  - `err_o=0` and `busy_o=0`.
  - All valid and ready outputs are 0, because no grant exists with no valid inputs.
  - Responses in flight at reset are not tracked; the surrounding system resets together.
- Request latency is 0 cycles, valid-to-valid and ready-to-ready. Response latency is 0 cycles.
- `busy_o` updates one cycle after a handshake. `err_o` follows the offending cycle by one cycle.
- A requester reaching MaxOutstanding via a handshake in cycle t is ineligible from cycle t+1.
- A decrement in cycle t makes the requester eligible again in t+1.
- A locked grant is held across any number of stall cycles, even if other requesters are at a higher priority.

## Test plan
- Reset, all requesters idle:
  - `mst_q_valid_o=0`, `slv_q_ready_o=0`, `busy_o=0`, `err_o=0`.
- All 4 requesters valid continuously, `mst_q_ready_i=1`, responses returned immediately:
  - Grants go 0,1,2,3,0.
  - `mst_q_id_o` upper bits match each grant.
- Requester 1 granted with `mst_q_ready_i=0` for 3 cycles while requester 0 is also valid:
  - Grant stays 1 for all 3 cycles.
  - The handshake completes on cycle 4.
  - `rr_q` becomes 2.
- Requester 2 issues 4 requests with no responses (MaxOutstanding=4):
  - The 5th request sees `slv_q_ready_o[2]=0`; requester 3 is granted instead.
  - After one response tagged 2, requester 2 is granted again.
- A response with id {2'd3, 5'd9} and `slv_p_ready_i[3]=0` for 2 cycles:
  - `slv_p_valid_o=4'b1000` and `mst_p_ready_o=0` for those 2 cycles.
  - The handshake then completes with `slv_p_id_o=9`.
  - `cnt_q[3]` decrements.
- NumReq=3, response tag 3:
  - Dropped with `mst_p_ready_o=1`.
  - `err_o` pulses one cycle later.
  - No counter changes.
